// File: rtl/line_buffer_scheduler_pkg.sv
// line_buffer_scheduler_pkg: geometry constants and FSM encodings shared by the line buffer scheduler.
package line_buffer_scheduler_pkg;
  localparam int PIX_IN_ROW    = 320;
  localparam int ROWS_IN_FRAME = 240;
  localparam int ADC_WIDHT     = 10;
  localparam int PIX_W         = $clog2(PIX_IN_ROW);
  localparam int ROW_W         = $clog2(ROWS_IN_FRAME);
  typedef enum logic {W_IDLE, W_FILL} w_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} r_state_e;
endpackage

// File: rtl/line_buffer_scheduler_line_rd_sequencer.sv
// line_rd_sequencer: drains one line per go pulse, paced by out_ready; tracks line index and frame end.
module line_rd_sequencer
  import line_buffer_scheduler_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             go,
  input  logic             out_ready,
  input  logic             frame_start,
  output logic             busy,
  output logic             rd_done,
  output logic             buf_out_en,
  output logic             line_rdy,
  output logic             frame_done,
  output logic [ROW_W-1:0] line_idx
);
  r_state_e         r_q, r_d;
  logic [PIX_W-1:0] rcnt_q, rcnt_d;
  logic [ROW_W-1:0] idx_q, idx_d;
  logic             oe_q, oe_d, fd_q, fd_d, last_row;
  always_comb begin
    busy     = r_q == R_DRAIN;
    rd_done  = busy && out_ready && rcnt_q == PIX_W'(PIX_IN_ROW - 1);
    last_row = idx_q == ROW_W'(ROWS_IN_FRAME - 1);
    r_d      = go ? R_DRAIN : rd_done ? R_IDLE : r_q;
    rcnt_d   = (go || rd_done) ? '0 : rcnt_q + PIX_W'(busy && out_ready);
  end
  always_comb begin
    oe_d  = busy && out_ready;
    fd_d  = rd_done && last_row;
    idx_d = frame_start ? '0 : !rd_done ? idx_q : last_row ? '0 : idx_q + 1'b1;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_q    <= R_IDLE;
      rcnt_q <= '0;
      idx_q  <= '0;
      oe_q   <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      r_q    <= r_d;
      rcnt_q <= rcnt_d;
      idx_q  <= idx_d;
      oe_q   <= oe_d;
      fd_q   <= fd_d;
    end
  end
  assign buf_out_en = oe_q;
  assign line_rdy   = busy;
  assign frame_done = fd_q;
  assign line_idx   = idx_q;
endmodule

// File: rtl/line_buffer_scheduler.sv
// line_buffer_scheduler: ping-pong line buffer sequencing between ADC writer and line reader.
// Optional LINE_DROP_CNT_EN adds a saturating drop_cnt output.
module line_buffer_scheduler
  import line_buffer_scheduler_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             line_start,
  input  logic             pix_valid,
  input  logic             frame_start,
  input  logic             out_ready,
  output logic             buf_sel,
  output logic             buf_in_en,
  output logic             buf_out_en,
  output logic             start_write,
  output logic [ROW_W-1:0] line_idx,
  output logic             line_rdy,
  output logic             frame_done,
  output logic             line_drop
`ifdef LINE_DROP_CNT_EN
  , output logic [15:0]    drop_cnt
`endif
);
  w_state_e         w_q, w_d;
  logic [PIX_W-1:0] wcnt_q, wcnt_d;
  logic             pending_q, pending_d, sel_q, sel_d, in_en_q, in_en_d, sw_q, sw_d, drop_q, drop_d;
  logic             line_complete, swap, busy, rd_done;
  always_comb begin
    line_complete = w_q == W_FILL && pix_valid && wcnt_q == PIX_W'(PIX_IN_ROW - 1);
    w_d       = w_q == W_IDLE ? ((line_start && !pending_q) ? W_FILL : W_IDLE) : (line_complete ? W_IDLE : W_FILL);
    wcnt_d    = (w_q != W_FILL || line_complete) ? '0 : wcnt_q + PIX_W'(pix_valid);
    // a line finishing exactly as the reader finishes swaps at once instead of waiting as pending
    swap      = (line_complete && (!busy || rd_done)) || (rd_done && pending_q);
    pending_d = swap ? 1'b0 : line_complete || pending_q;
  end
  always_comb begin
    sel_d   = sel_q ^ swap;
    in_en_d = w_q == W_FILL && pix_valid;
    sw_d    = swap;
    drop_d  = w_q == W_IDLE && line_start && pending_q;
  end
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      w_q       <= W_IDLE;
      wcnt_q    <= '0;
      pending_q <= 1'b0;
      sel_q     <= 1'b0;
      in_en_q   <= 1'b0;
      sw_q      <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      w_q       <= w_d;
      wcnt_q    <= wcnt_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      in_en_q   <= in_en_d;
      sw_q      <= sw_d;
      drop_q    <= drop_d;
    end
  end
  line_rd_sequencer u_rd (
    .CLK         (CLK),
    .RESET       (RESET),
    .go          (swap),
    .out_ready   (out_ready),
    .frame_start (frame_start),
    .busy        (busy),
    .rd_done     (rd_done),
    .buf_out_en  (buf_out_en),
    .line_rdy    (line_rdy),
    .frame_done  (frame_done),
    .line_idx    (line_idx)
  );
  assign buf_sel     = sel_q;
  assign buf_in_en   = in_en_q;
  assign start_write = sw_q;
  assign line_drop   = drop_q;
`ifdef LINE_DROP_CNT_EN
  logic [15:0] dcnt_q, dcnt_d;
  always_comb dcnt_d = frame_start ? '0 : (drop_d && dcnt_q != 16'hFFFF) ? dcnt_q + 1'b1 : dcnt_q;
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) dcnt_q <= '0;
    else dcnt_q <= dcnt_d;
  end
  assign drop_cnt = dcnt_q;
`endif
endmodule

// File: tb/tb_line_buffer_scheduler.sv
// tb_line_buffer_scheduler: directed self-checking bench for line_buffer_scheduler.
module tb_line_buffer_scheduler;
  import line_buffer_scheduler_pkg::*;
  logic             CLK = 0, RESET = 0, line_start = 0, pix_valid = 0, frame_start = 0, out_ready = 0;
  logic             buf_sel, buf_in_en, buf_out_en, start_write, line_rdy, frame_done, line_drop;
  logic [ROW_W-1:0] line_idx;
`ifdef LINE_DROP_CNT_EN
  logic [15:0]      drop_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  int c_sw, c_oe, c_ie, c_drop, c_fd, fd_idx;
  line_buffer_scheduler dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .line_start  (line_start),
    .pix_valid   (pix_valid),
    .frame_start (frame_start),
    .out_ready   (out_ready),
    .buf_sel     (buf_sel),
    .buf_in_en   (buf_in_en),
    .buf_out_en  (buf_out_en),
    .start_write (start_write),
    .line_idx    (line_idx),
    .line_rdy    (line_rdy),
    .frame_done  (frame_done),
    .line_drop   (line_drop)
`ifdef LINE_DROP_CNT_EN
    , .drop_cnt  (drop_cnt)
`endif
  );
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    c_sw = 0; c_oe = 0; c_ie = 0; c_drop = 0; c_fd = 0; fd_idx = -1;
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      c_sw   += int'(start_write);
      c_oe   += int'(buf_out_en);
      c_ie   += int'(buf_in_en);
      c_drop += int'(line_drop);
      c_fd   += int'(frame_done);
      if (frame_done) fd_idx = int'(line_idx);
    end
  endtask
  task automatic reset_dut();
    line_start = 0; pix_valid = 0; frame_start = 0; out_ready = 0;
    RESET = 1;
    run(2);
    RESET = 0;
    run(1);
    clr();
  endtask
  task automatic fill_line(input int n);
    line_start = 1;
    run(1);
    line_start = 0; pix_valid = 1;
    run(n);
    pix_valid = 0;
  endtask
  initial begin
    reset_dut();
    check("rst_buf_sel", buf_sel, 0);
    check("rst_line_idx", line_idx, 0);
    check("rst_outs", {buf_in_en, buf_out_en, start_write, line_rdy, frame_done, line_drop}, 0);
    // single line, reader always ready
    out_ready = 1;
    fill_line(320);
    check("t1_sw_at_complete", start_write, 1);
    check("t1_sel_at_complete", buf_sel, 1);
    check("t1_oe_not_yet", buf_out_en, 0);
    check("t1_rdy", line_rdy, 1);
    run(1);
    check("t1_first_oe", buf_out_en, 1);
    run(340);
    check("t1_sw_cnt", c_sw, 1);
    check("t1_ie_cnt", c_ie, 320);
    check("t1_oe_cnt", c_oe, 320);
    check("t1_line_idx", line_idx, 1);
    check("t1_rdy_end", line_rdy, 0);
    check("t1_drop_cnt", c_drop, 0);
    frame_start = 1;
    run(1);
    frame_start = 0;
    check("t1_frame_start_clr", line_idx, 0);
    // stalled reader: pending line, then a refused line_start
    reset_dut();
    fill_line(320);
    fill_line(320);
    check("t2_pending", dut.pending_q, 1);
    check("t2_sel_hold", buf_sel, 1);
    check("t2_sw_cnt", c_sw, 1);
    line_start = 1;
    run(1);
    check("t2_drop_pulse", line_drop, 1);
    line_start = 0; pix_valid = 1;
    run(5);
    pix_valid = 0;
    check("t2_drop_once", c_drop, 1);
    check("t2_ie_ignored", c_ie, 640);
    out_ready = 1;
    run(319);
    check("t2_sel_before_end", buf_sel, 1);
    run(1);
    check("t2_sel_swap", buf_sel, 0);
    check("t2_sw_swap", start_write, 1);
    check("t2_pending_clr", dut.pending_q, 0);
    run(330);
    check("t2_oe_cnt", c_oe, 640);
    check("t2_line_idx", line_idx, 2);
    check("t2_sw_total", c_sw, 2);
    // line complete coincides with drain end
    reset_dut();
    out_ready = 1;
    fill_line(320);
    out_ready = 0; line_start = 1;
    run(1);
    line_start = 0; out_ready = 1; pix_valid = 1;
    run(320);
    pix_valid = 0;
    check("t3_sel", buf_sel, 0);
    check("t3_sw", start_write, 1);
    check("t3_no_pending", dut.pending_q, 0);
    run(1);
    check("t3_oe", buf_out_en, 1);
    run(330);
    check("t3_drop", c_drop, 0);
    check("t3_sw_cnt", c_sw, 2);
    check("t3_oe_cnt", c_oe, 640);
    check("t3_line_idx", line_idx, 2);
    // full frame of back-to-back lines
    reset_dut();
    out_ready = 1;
    for (int k = 0; k < 239; k++) fill_line(320);
    check("t4_fd_early", c_fd, 0);
    check("t4_idx_238", line_idx, 238);
    fill_line(320);
    run(330);
    check("t4_fd_once", c_fd, 1);
    check("t4_fd_idx_wrap", fd_idx, 0);
    check("t4_line_idx", line_idx, 0);
    check("t4_sw_cnt", c_sw, 240);
    check("t4_oe_cnt", c_oe, 76800);
    check("t4_drop", c_drop, 0);
    // asynchronous reset in the middle of a fill
    reset_dut();
    out_ready = 1;
    fill_line(320);
    line_start = 1;
    run(1);
    line_start = 0; pix_valid = 1;
    run(100);
    check("t5_pre_sel", buf_sel, 1);
    check("t5_pre_ie", buf_in_en, 1);
    RESET = 1;
    #2;
    check("t5_async_sel", buf_sel, 0);
    check("t5_async_idx", line_idx, 0);
    check("t5_async_outs", {buf_in_en, buf_out_en, start_write, line_rdy, frame_done, line_drop}, 0);
    pix_valid = 0;
    run(2);
    RESET = 0;
    run(1);
    clr();
    fill_line(320);
    run(341);
    check("t5_sw_cnt", c_sw, 1);
    check("t5_sel", buf_sel, 1);
    check("t5_oe_cnt", c_oe, 320);
    check("t5_line_idx", line_idx, 1);
`ifdef LINE_DROP_CNT_EN
    reset_dut();
    fill_line(320);
    fill_line(320);
    for (int k = 0; k < 3; k++) begin
      line_start = 1;
      run(1);
      line_start = 0;
      run(2);
    end
    check("t6_drop_cnt", drop_cnt, 3);
    frame_start = 1;
    run(1);
    frame_start = 0;
    check("t6_drop_cnt_clr", drop_cnt, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
